// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC parallel-bus sequencers (read and write).
package rtc_pkg;

  // Default wait budget for a bus phase before the sequencer gives up.
  localparam int unsigned TIMEOUT_CYC_DEF = 1023;
  localparam int unsigned CNT_W_DEF       = 10;

  // Value presented on the address lines when the sequencer does not own the bus.
  localparam logic [7:0] BUS_IDLE = 8'h00;

  // Read sequencer states.
  typedef enum logic [2:0] {
    RD_IDLE = 3'd0,
    RD_ADDR = 3'd1,
    RD_READ = 3'd2,
    RD_DONE = 3'd3,
    RD_ERR  = 3'd4,
    RD_WREL = 3'd5
  } rd_state_e;

  // Write sequencer states.
  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_DONE = 3'd3,
    WR_ERR  = 3'd4,
    WR_WREL = 3'd5
  } wr_state_e;

  // True in the states where the read sequencer is waiting on the bus driver.
  function automatic logic rd_waits_fin(rd_state_e s);
    return (s == RD_ADDR) || (s == RD_READ);
  endfunction

endpackage

// File: rtl/rtc_tmo_cnt.sv
// Phase timeout counter shared by the RTC read and write sequencers.
// tc_o is high in the cycle whose increment would make the count reach TIMEOUT_CYC,
// so the owner can leave the phase on that same edge (after TIMEOUT_CYC idle cycles).
module rtc_tmo_cnt #(
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TcVal = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TcVal);

  // Clear wins over enable; the count parks at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_lectura_seq.sv
// RTC read sequencer: address phase, read-strobe phase, byte capture, completion pulse.
// All outputs are registered alongside the state register (Moore).
module rtc_lectura_seq
  import rtc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar_i,
  input  logic [7:0] dir_i,
  input  logic       fin_i,
  input  logic [7:0] data_in_i,
  output logic [7:0] dir_out_o,
  output logic       lee_o,
  output logic       activa_o,
  output logic [7:0] dato_o,
  output logic       final_o,
  output logic       error_o
);

  rd_state_e  state_q, state_d;
  logic [7:0] dir_out_q, dir_out_d;
  logic [7:0] dato_q, dato_d;
  logic       lee_q, lee_d;
  logic       activa_q, activa_d;
  logic       final_q, final_d;
  logic       error_q, error_d;

  logic tmo_clr, tmo_en, tmo_tc;

  // Restart the budget on every entry into a waiting phase; count only idle waiting cycles.
  assign tmo_clr = (state_d != state_q) && rd_waits_fin(state_d);
  assign tmo_en  = rd_waits_fin(state_q) && !fin_i;

  rtc_tmo_cnt #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk  (clk),
    .reset(reset),
    .clr_i(tmo_clr),
    .en_i (tmo_en),
    .tc_o (tmo_tc)
  );

  // Next state: abort beats fin, fin beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: begin
        if (iniciar_i) state_d = RD_ADDR;
      end
      RD_ADDR: begin
        if (!iniciar_i) state_d = RD_IDLE;
        else if (fin_i) state_d = RD_READ;
        else if (tmo_tc) state_d = RD_ERR;
      end
      RD_READ: begin
        if (!iniciar_i) state_d = RD_IDLE;
        else if (fin_i) state_d = RD_DONE;
        else if (tmo_tc) state_d = RD_ERR;
      end
      RD_DONE: state_d = RD_WREL;
      RD_ERR:  state_d = RD_WREL;
      RD_WREL: begin
        // A held request must drop before another read can start.
        if (!iniciar_i) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    dir_out_d = BUS_IDLE;
    lee_d     = 1'b0;
    activa_d  = 1'b0;
    final_d   = 1'b0;
    error_d   = 1'b0;
    dato_d    = dato_q;
    case (state_d)
      RD_ADDR: begin
        activa_d  = 1'b1;
        // Address is latched only on acceptance; later dir changes are ignored.
        dir_out_d = (state_q == RD_IDLE) ? dir_i : dir_out_q;
      end
      RD_READ: begin
        activa_d  = 1'b1;
        lee_d     = 1'b1;
        dir_out_d = dir_out_q;
      end
      RD_DONE: final_d = 1'b1;
      RD_ERR: begin
        final_d = 1'b1;
        error_d = 1'b1;
      end
      default: ;
    endcase
    if ((state_q == RD_READ) && (state_d == RD_DONE)) begin
      dato_d = data_in_i;
    end
  end

  // State and registered outputs; reset clears the captured byte as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RD_IDLE;
      dir_out_q <= BUS_IDLE;
      lee_q     <= 1'b0;
      activa_q  <= 1'b0;
      dato_q    <= 8'h00;
      final_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_out_q <= dir_out_d;
      lee_q     <= lee_d;
      activa_q  <= activa_d;
      dato_q    <= dato_d;
      final_q   <= final_d;
      error_q   <= error_d;
    end
  end

  assign dir_out_o = dir_out_q;
  assign lee_o     = lee_q;
  assign activa_o  = activa_q;
  assign dato_o    = dato_q;
  assign final_o   = final_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_rtc_lectura_seq.sv
// Self-checking bench for rtc_lectura_seq with a short timeout budget.
module tb_rtc_lectura_seq;

  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [7:0] dir;
  logic       fin;
  logic [7:0] data_in;
  logic [7:0] dir_out;
  logic       lee;
  logic       activa;
  logic [7:0] dato;
  logic       final_p;
  logic       error_p;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: last byte of a successful read, cleared by reset.
  logic [7:0] model_dato = 8'h00;

  rtc_lectura_seq #(
    .TIMEOUT_CYC(TMO),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iniciar_i(iniciar),
    .dir_i    (dir),
    .fin_i    (fin),
    .data_in_i(data_in),
    .dir_out_o(dir_out),
    .lee_o    (lee),
    .activa_o (activa),
    .dato_o   (dato),
    .final_o  (final_p),
    .error_o  (error_p)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name, input logic [7:0] exp_dato);
    n_checks++;
    if ({activa, lee, final_p, error_p, dir_out} !== 12'h000 || dato !== exp_dato) begin
      n_fail++;
      $display("FAIL %s: activa=%b lee=%b final=%b error=%b dir_out=%h dato=%h, required all 0, dato=%h",
               name, activa, lee, final_p, error_p, dir_out, dato, exp_dato);
    end
  endtask

  // One transaction: fin d1 cycles into the address phase, d2 cycles into the read phase.
  // Phase lengths, pulses and the captured byte are predicted from the timeout rule alone.
  task automatic run_txn(input string name, input logic [7:0] d, input logic [7:0] d_late,
                         input int d1, input int d2, input logic [7:0] data, input bit release_req);
    int n_act = 0, n_lee = 0, n_fin = 0, n_err = 0, first_fin = -1;
    int exp_act, exp_lee, n_run;
    bit ok, dir_ok = 1'b1;
    if (d1 >= int'(TMO)) begin
      exp_act = TMO; exp_lee = 0; ok = 1'b0;
    end else if (d2 >= int'(TMO)) begin
      exp_act = d1 + 1 + TMO; exp_lee = TMO; ok = 1'b0;
    end else begin
      exp_act = d1 + d2 + 2; exp_lee = d2 + 1; ok = 1'b1;
    end
    if (ok) model_dato = data;
    n_run = d1 + d2 + TMO + 6;

    iniciar = 1'b1; dir = d; fin = 1'b0;
    tick();
    n_checks++;
    if (activa !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: activa=%b after accept edge, required 1", name, activa);
    end
    dir = d_late;
    for (int cyc = 0; cyc < n_run; cyc++) begin
      if (activa === 1'b1) begin
        n_act++;
        if (dir_out !== d) dir_ok = 1'b0;
      end
      if (lee === 1'b1) n_lee++;
      if (final_p === 1'b1) begin
        n_fin++;
        if (first_fin < 0) first_fin = cyc;
      end
      if (error_p === 1'b1) n_err++;
      fin     = (cyc == d1) || (cyc == d1 + 1 + d2);
      data_in = (cyc == d1 + 1 + d2) ? data : 8'($urandom);
      tick();
    end
    fin = 1'b0;

    n_checks++;
    if (n_act != exp_act) begin
      n_fail++; $display("FAIL %s activa cycles: got %0d, required %0d", name, n_act, exp_act);
    end
    n_checks++;
    if (n_lee != exp_lee) begin
      n_fail++; $display("FAIL %s lee cycles: got %0d, required %0d", name, n_lee, exp_lee);
    end
    n_checks++;
    if (n_fin != 1 || first_fin != exp_act) begin
      n_fail++;
      $display("FAIL %s final: %0d pulses at cycle %0d, required 1 at cycle %0d",
               name, n_fin, first_fin, exp_act);
    end
    n_checks++;
    if (n_err != (ok ? 0 : 1)) begin
      n_fail++; $display("FAIL %s error pulses: got %0d, required %0d", name, n_err, ok ? 0 : 1);
    end
    n_checks++;
    if (!dir_ok) begin
      n_fail++; $display("FAIL %s dir_out: not held at %h while activa", name, d);
    end
    n_checks++;
    if (dato !== model_dato) begin
      n_fail++; $display("FAIL %s dato: got %h, required %h", name, dato, model_dato);
    end
    if (release_req) begin
      iniciar = 1'b0;
      tick();
      check_quiet({name, " release"}, model_dato);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; dir = 8'h00; fin = 1'b0; data_in = 8'h00;
    tick();
    tick();
    check_quiet("reset", 8'h00);
    reset = 1'b0;
    tick();
    check_quiet("post_reset_idle", 8'h00);
  endtask

  task automatic test_basic_read();
    run_txn("basic", 8'h23, 8'h23, 3, 2, 8'h59, 1'b0);
  endtask

  // Request stays high after completion: no retrigger until it drops and rises again.
  task automatic test_held_request();
    int n_act = 0;
    for (int i = 0; i < 10; i++) begin
      if (activa === 1'b1 || final_p === 1'b1) n_act++;
      tick();
    end
    n_checks++;
    if (n_act != 0) begin
      n_fail++; $display("FAIL held_request: %0d busy cycles while held, required 0", n_act);
    end
    iniciar = 1'b0;
    tick();
    check_quiet("held_drop", model_dato);
    iniciar = 1'b1; dir = 8'h42;
    tick();
    n_checks++;
    if (activa !== 1'b1 || dir_out !== 8'h42) begin
      n_fail++;
      $display("FAIL held_rearm: activa=%b dir_out=%h, required 1 and 42", activa, dir_out);
    end
    iniciar = 1'b0;
    tick();
    check_quiet("held_abort", model_dato);
    tick();
  endtask

  task automatic test_timeout();
    run_txn("timeout_addr", 8'h10, 8'h11, TMO + 4, 0, 8'hC3, 1'b1);
    run_txn("timeout_read", 8'h12, 8'h13, 1, TMO, 8'hC4, 1'b1);
    run_txn("fin_at_limit_addr", 8'h14, 8'h15, TMO - 1, 0, 8'h5A, 1'b1);
    run_txn("fin_at_limit_read", 8'h16, 8'h17, 0, TMO - 1, 8'hA5, 1'b1);
  endtask

  // Request withdrawn on the very cycle the read completes.
  task automatic test_abort();
    int n_fin = 0;
    iniciar = 1'b1; dir = 8'h31; fin = 1'b0;
    tick();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    tick();
    n_checks++;
    if (lee !== 1'b1 || activa !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: lee=%b activa=%b, required 1 1", lee, activa);
    end
    iniciar = 1'b0; fin = 1'b1; data_in = 8'hAA;
    tick();
    fin = 1'b0;
    check_quiet("abort", model_dato);
    for (int i = 0; i < 4; i++) begin
      if (final_p === 1'b1) n_fin++;
      tick();
    end
    n_checks++;
    if (n_fin != 0) begin
      n_fail++; $display("FAIL abort_final: %0d final pulses, required 0", n_fin);
    end
  endtask

  task automatic test_stray_fin();
    int n_busy = 0;
    iniciar = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fin = i[0];
      data_in = 8'($urandom);
      tick();
      if (activa === 1'b1 || final_p === 1'b1 || lee === 1'b1) n_busy++;
    end
    fin = 1'b0;
    n_checks++;
    if (n_busy != 0 || dato !== model_dato) begin
      n_fail++;
      $display("FAIL stray_fin: %0d busy cycles, dato=%h, required 0 and %h", n_busy, dato, model_dato);
    end
    run_txn("dir_change", 8'h23, 8'h24, 2, 1, 8'h6E, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    iniciar = 1'b1; dir = 8'h55; fin = 1'b0;
    tick();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    reset = 1'b1; iniciar = 1'b0;
    tick();
    model_dato = 8'h00;
    check_quiet("reset_mid_read", model_dato);
    tick();
    reset = 1'b0;
    tick();
    check_quiet("after_mid_reset", model_dato);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_txn("random", 8'($urandom), 8'($urandom), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 10)), 8'($urandom), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_held_request();
    test_timeout();
    test_abort();
    test_stray_fin();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
